// File: rtl/mem_arb_pkg.sv
// Shared definitions for the mem_1r1w two-requester arbiter: requester IDs,
// counter defaults and a small one-hot helper.
package mem_arb_pkg;

    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_id_e;

    localparam int                   CNT_W_DEF   = 16;
    localparam logic [CNT_W_DEF-1:0] CNT_SAT_DEF = {CNT_W_DEF{1'b1}};

    function automatic logic [1:0] id_onehot(input req_id_e id);
        return (id == REQ_M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational from req and the
// preference pointer; the pointer flips to the other requester after any grant.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_id_e pref_q;
    req_id_e pref_d;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt = 2'b00;
        if (rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = id_onehot(pref_q);
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        pref_d = pref_q;
        if (gnt[0]) begin
            pref_d = REQ_M1;
        end else if (gnt[1]) begin
            pref_d = REQ_M0;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // the pre-edge value of its inputs, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pref_q <= REQ_M0;
        end else begin
            pref_q <= pref_d;
        end
    end

endmodule

// File: rtl/mem_1r1w_arbiter.sv
// Shares one mem_1r1w between requesters m0 and m1 with independent round-robin
// read/write channels. Optional read-after-write forwarding: MEM_ARB_RAW_FWD_EN.
module mem_1r1w_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_rd_req,
    input  logic [ADDR_W-1:0] m0_rd_addr,
    output logic              m0_rd_gnt,
    output logic              m0_rd_vld,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_rd_req,
    input  logic [ADDR_W-1:0] m1_rd_addr,
    output logic              m1_rd_gnt,
    output logic              m1_rd_vld,
    output logic [DATA_W-1:0] m1_rd_data,

    input  logic              m0_wr_req,
    input  logic [ADDR_W-1:0] m0_wr_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_wr_gnt,
    input  logic              m1_wr_req,
    input  logic [ADDR_W-1:0] m1_wr_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_wr_gnt,

    output logic [ADDR_W-1:0] mem_rd_addr0,
    output logic [ADDR_W-1:0] mem_wr_addr0,
    output logic [DATA_W-1:0] mem_wr_din0,
    output logic              mem_we0,
    input  logic [DATA_W-1:0] mem_rd_dout0,

    output logic [CNT_W-1:0]  rd_conflict_cnt,
    output logic [CNT_W-1:0]  wr_conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    logic [1:0] rd_req;
    logic [1:0] rd_gnt;
    logic [1:0] wr_req;
    logic [1:0] wr_gnt;

    assign rd_req = {m1_rd_req, m0_rd_req};
    assign wr_req = {m1_wr_req, m0_wr_req};

    rr_arb2 u_rd_arb (
        .clk (clk),
        .rst (rst),
        .req (rd_req),
        .gnt (rd_gnt)
    );

    rr_arb2 u_wr_arb (
        .clk (clk),
        .rst (rst),
        .req (wr_req),
        .gnt (wr_gnt)
    );

    assign m0_rd_gnt = rd_gnt[0];
    assign m1_rd_gnt = rd_gnt[1];
    assign m0_wr_gnt = wr_gnt[0];
    assign m1_wr_gnt = wr_gnt[1];

    // Idle channels park on m0's address/data so the memory inputs never float.
    always_comb begin
        mem_wr_addr0 = m0_wr_addr;
        mem_wr_din0  = m0_wr_data;
        if (wr_gnt[1]) begin
            mem_wr_addr0 = m1_wr_addr;
            mem_wr_din0  = m1_wr_data;
        end
        mem_we0 = |wr_gnt;
    end

    always_comb begin
        mem_rd_addr0 = m0_rd_addr;
        if (rd_gnt[1]) begin
            mem_rd_addr0 = m1_rd_addr;
        end
    end

    logic    rd_vld_q;
    logic    rd_vld_d;
    req_id_e rd_owner_q;
    req_id_e rd_owner_d;

    always_comb begin
        rd_vld_d   = |rd_gnt;
        rd_owner_d = rd_owner_q;
        if (rd_gnt[1]) begin
            rd_owner_d = REQ_M1;
        end else if (rd_gnt[0]) begin
            rd_owner_d = REQ_M0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_q   <= 1'b0;
            rd_owner_q <= REQ_M0;
        end else begin
            rd_vld_q   <= rd_vld_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign m0_rd_vld = rd_vld_q && (rd_owner_q == REQ_M0);
    assign m1_rd_vld = rd_vld_q && (rd_owner_q == REQ_M1);

    logic [DATA_W-1:0] rd_data_mux;

`ifdef MEM_ARB_RAW_FWD_EN
    logic              fwd_q;
    logic              fwd_d;
    logic [DATA_W-1:0] fwd_data_q;
    logic [DATA_W-1:0] fwd_data_d;

    always_comb begin
        fwd_d      = (|rd_gnt) && (|wr_gnt) && (mem_rd_addr0 == mem_wr_addr0);
        fwd_data_d = fwd_d ? mem_wr_din0 : fwd_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_q <= 1'b0;
        end else begin
            fwd_q <= fwd_d;
        end
    end

    // NOTE: the forwarded data register is left without reset; it is only
    // observed while fwd_q is set, and fwd_q itself is reset.
    always_ff @(posedge clk) begin
        fwd_data_q <= fwd_data_d;
    end

    always_comb begin
        rd_data_mux = fwd_q ? fwd_data_q : mem_rd_dout0;
    end
`else
    always_comb begin
        rd_data_mux = mem_rd_dout0;
    end
`endif

    assign m0_rd_data = rd_data_mux;
    assign m1_rd_data = rd_data_mux;

    logic [CNT_W-1:0] rd_cnt_q;
    logic [CNT_W-1:0] rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q;
    logic [CNT_W-1:0] wr_cnt_d;

    // Contention is counted on requests, not grants, and holds at all-ones.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if ((&rd_req) && (rd_cnt_q != CNT_SAT)) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
        if ((&wr_req) && (wr_cnt_q != CNT_SAT)) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_conflict_cnt = rd_cnt_q;
    assign wr_conflict_cnt = wr_cnt_q;

endmodule

// File: tb/tb_mem_1r1w_arbiter.sv
// Self-checking bench for mem_1r1w_arbiter: directed scenarios plus randomized
// traffic against a last-winner reference model and a behavioural mem_1r1w.
module tb_mem_1r1w_arbiter;

    localparam int DW      = 32;
    localparam int AW      = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          m0_rd_req, m1_rd_req;
    logic [AW-1:0] m0_rd_addr, m1_rd_addr;
    logic          m0_rd_gnt, m1_rd_gnt;
    logic          m0_rd_vld, m1_rd_vld;
    logic [DW-1:0] m0_rd_data, m1_rd_data;
    logic          m0_wr_req, m1_wr_req;
    logic [AW-1:0] m0_wr_addr, m1_wr_addr;
    logic [DW-1:0] m0_wr_data, m1_wr_data;
    logic          m0_wr_gnt, m1_wr_gnt;
    logic [AW-1:0] mem_rd_addr0, mem_wr_addr0;
    logic [DW-1:0] mem_wr_din0, mem_rd_dout0;
    logic          mem_we0;
    logic [CW-1:0] rd_conflict_cnt, wr_conflict_cnt;

    mem_1r1w_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .m0_rd_req       (m0_rd_req),
        .m0_rd_addr      (m0_rd_addr),
        .m0_rd_gnt       (m0_rd_gnt),
        .m0_rd_vld       (m0_rd_vld),
        .m0_rd_data      (m0_rd_data),
        .m1_rd_req       (m1_rd_req),
        .m1_rd_addr      (m1_rd_addr),
        .m1_rd_gnt       (m1_rd_gnt),
        .m1_rd_vld       (m1_rd_vld),
        .m1_rd_data      (m1_rd_data),
        .m0_wr_req       (m0_wr_req),
        .m0_wr_addr      (m0_wr_addr),
        .m0_wr_data      (m0_wr_data),
        .m0_wr_gnt       (m0_wr_gnt),
        .m1_wr_req       (m1_wr_req),
        .m1_wr_addr      (m1_wr_addr),
        .m1_wr_data      (m1_wr_data),
        .m1_wr_gnt       (m1_wr_gnt),
        .mem_rd_addr0    (mem_rd_addr0),
        .mem_wr_addr0    (mem_wr_addr0),
        .mem_wr_din0     (mem_wr_din0),
        .mem_we0         (mem_we0),
        .mem_rd_dout0    (mem_rd_dout0),
        .rd_conflict_cnt (rd_conflict_cnt),
        .wr_conflict_cnt (wr_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural mem_1r1w: synchronous read returning the pre-write contents.
    logic [DW-1:0] tb_mem [16];
    always @(posedge clk) begin
        if (mem_we0) tb_mem[mem_wr_addr0] <= mem_wr_din0;
        mem_rd_dout0 <= tb_mem[mem_rd_addr0];
    end

    int n_chk;
    int n_err;

    // Reference model: who won last on each channel, what the memory holds,
    // which read is due back next cycle, and the contention counts.
    logic [DW-1:0] ref_mem [16];
    int            rd_last, wr_last;
    int            rd_win, wr_win;
    int            rd_cnt_m, wr_cnt_m;
    bit            pend_vld;
    int            pend_owner;
    logic [DW-1:0] pend_data;

    function automatic int pick(input logic r0, input logic r1, input int last);
        if (r0 && r1) return (last == 0) ? 1 : 0;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        rd_last  = 1;
        wr_last  = 1;
        rd_win   = -1;
        wr_win   = -1;
        rd_cnt_m = 0;
        wr_cnt_m = 0;
        pend_vld = 1'b0;
    endtask

    task automatic idle_inputs();
        m0_rd_req = 1'b0; m1_rd_req = 1'b0;
        m0_wr_req = 1'b0; m1_wr_req = 1'b0;
        m0_rd_addr = '0;  m1_rd_addr = '0;
        m0_wr_addr = '0;  m1_wr_addr = '0;
        m0_wr_data = '0;  m1_wr_data = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Compares every output against the model for the current cycle, then
    // advances the model and the clock. Returns at posedge+1.
    task automatic step_cycle();
        logic [1:0]    exp_rg, exp_wg, exp_vld;
        logic [AW-1:0] exp_ra, exp_wa;
        logic [DW-1:0] exp_wd;
        logic [CW-1:0] exp_rc, exp_wc;
        #3;
        rd_win = pick(m0_rd_req, m1_rd_req, rd_last);
        wr_win = pick(m0_wr_req, m1_wr_req, wr_last);
        exp_rg = (rd_win == 0) ? 2'b01 : (rd_win == 1) ? 2'b10 : 2'b00;
        exp_wg = (wr_win == 0) ? 2'b01 : (wr_win == 1) ? 2'b10 : 2'b00;
        exp_ra = (rd_win == 1) ? m1_rd_addr : m0_rd_addr;
        exp_wa = (wr_win == 1) ? m1_wr_addr : m0_wr_addr;
        exp_wd = (wr_win == 1) ? m1_wr_data : m0_wr_data;
        exp_vld = !pend_vld ? 2'b00 : (pend_owner == 0) ? 2'b01 : 2'b10;
        exp_rc = rd_cnt_m[CW-1:0];
        exp_wc = wr_cnt_m[CW-1:0];

        n_chk++;
        if ({m1_rd_gnt, m0_rd_gnt} !== exp_rg) begin
            n_err++;
            $display("FAIL rd_gnt @%0t: got %b expected %b", $time, {m1_rd_gnt, m0_rd_gnt}, exp_rg);
        end
        n_chk++;
        if ({m1_wr_gnt, m0_wr_gnt} !== exp_wg) begin
            n_err++;
            $display("FAIL wr_gnt @%0t: got %b expected %b", $time, {m1_wr_gnt, m0_wr_gnt}, exp_wg);
        end
        n_chk++;
        if (mem_we0 !== (wr_win >= 0)) begin
            n_err++;
            $display("FAIL mem_we0 @%0t: got %b expected %b", $time, mem_we0, (wr_win >= 0));
        end
        n_chk++;
        if (mem_rd_addr0 !== exp_ra) begin
            n_err++;
            $display("FAIL mem_rd_addr0 @%0t: got %h expected %h", $time, mem_rd_addr0, exp_ra);
        end
        n_chk++;
        if ({mem_wr_addr0, mem_wr_din0} !== {exp_wa, exp_wd}) begin
            n_err++;
            $display("FAIL mem_wr @%0t: got %h/%h expected %h/%h", $time, mem_wr_addr0, mem_wr_din0, exp_wa, exp_wd);
        end
        n_chk++;
        if ({m1_rd_vld, m0_rd_vld} !== exp_vld) begin
            n_err++;
            $display("FAIL rd_vld @%0t: got %b expected %b", $time, {m1_rd_vld, m0_rd_vld}, exp_vld);
        end
        if (pend_vld) begin
            n_chk++;
            if (((pend_owner == 0) ? m0_rd_data : m1_rd_data) !== pend_data) begin
                n_err++;
                $display("FAIL rd_data @%0t: got %h expected %h (owner m%0d)", $time,
                         (pend_owner == 0) ? m0_rd_data : m1_rd_data, pend_data, pend_owner);
            end
        end
        n_chk++;
        if ({rd_conflict_cnt, wr_conflict_cnt} !== {exp_rc, exp_wc}) begin
            n_err++;
            $display("FAIL conflict_cnt @%0t: got %0d/%0d expected %0d/%0d", $time,
                     rd_conflict_cnt, wr_conflict_cnt, exp_rc, exp_wc);
        end

        if (m0_rd_req && m1_rd_req && rd_cnt_m < CNT_MAX) rd_cnt_m++;
        if (m0_wr_req && m1_wr_req && wr_cnt_m < CNT_MAX) wr_cnt_m++;
        pend_vld = (rd_win >= 0);
        if (rd_win >= 0) begin
            pend_owner = rd_win;
            pend_data  = ref_mem[exp_ra];
`ifdef MEM_ARB_RAW_FWD_EN
            if (wr_win >= 0 && exp_wa == exp_ra) pend_data = exp_wd;
`endif
            rd_last = rd_win;
        end
        if (wr_win >= 0) begin
            ref_mem[exp_wa] = exp_wd;
            wr_last = wr_win;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_rd_req = 1'b1; m1_rd_req = 1'b1;
        m0_wr_req = 1'b1; m1_wr_req = 1'b1;
        #3;
        n_chk++;
        if ({m1_rd_gnt, m0_rd_gnt, m1_wr_gnt, m0_wr_gnt, mem_we0} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_gnt: got %b expected 00000",
                     {m1_rd_gnt, m0_rd_gnt, m1_wr_gnt, m0_wr_gnt, mem_we0});
        end
        @(posedge clk);
        #1;
        n_chk++;
        if ({m1_rd_vld, m0_rd_vld} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_vld: got %b expected 00", {m1_rd_vld, m0_rd_vld});
        end
        n_chk++;
        if ({rd_conflict_cnt, wr_conflict_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", rd_conflict_cnt, wr_conflict_cnt);
        end
        rst = 1'b1;
        model_reset();
        step_cycle();
        idle_inputs();
        step_cycle();
    endtask

    task automatic test_write_contention();
        apply_reset();
        m0_wr_req = 1'b1; m0_wr_addr = 4'd0; m0_wr_data = 32'd31;
        m1_wr_req = 1'b1; m1_wr_addr = 4'd1; m1_wr_data = 32'hA5;
        #1;
        n_chk++;
        if ({m1_wr_gnt, m0_wr_gnt, mem_we0} !== 3'b011) begin
            n_err++;
            $display("FAIL wc_first: got %b expected 011", {m1_wr_gnt, m0_wr_gnt, mem_we0});
        end
        step_cycle();
        m0_wr_req = 1'b0;
        #1;
        n_chk++;
        if ({m1_wr_gnt, m0_wr_gnt, mem_we0} !== 3'b101) begin
            n_err++;
            $display("FAIL wc_second: got %b expected 101", {m1_wr_gnt, m0_wr_gnt, mem_we0});
        end
        step_cycle();
        m1_wr_req = 1'b0;
        #1;
        n_chk++;
        if (wr_conflict_cnt !== 4'd1) begin
            n_err++;
            $display("FAIL wc_count: got %0d expected 1", wr_conflict_cnt);
        end
        step_cycle();
    endtask

    task automatic test_read_routing();
        apply_reset();
        m1_rd_req = 1'b1; m1_rd_addr = 4'd1;
        step_cycle();
        m1_rd_req = 1'b0;
        m0_rd_req = 1'b1; m0_rd_addr = 4'd0;
        #1;
        n_chk++;
        if ({m1_rd_vld, m0_rd_vld, m1_rd_data} !== {2'b10, 32'hA5}) begin
            n_err++;
            $display("FAIL rr_m1: got vld=%b data=%h expected vld=10 data=a5", {m1_rd_vld, m0_rd_vld}, m1_rd_data);
        end
        step_cycle();
        m0_rd_req = 1'b0;
        #1;
        n_chk++;
        if ({m1_rd_vld, m0_rd_vld, m0_rd_data} !== {2'b01, 32'd31}) begin
            n_err++;
            $display("FAIL rr_m0: got vld=%b data=%h expected vld=01 data=1f", {m1_rd_vld, m0_rd_vld}, m0_rd_data);
        end
        step_cycle();
    endtask

    task automatic test_concurrent();
        apply_reset();
        m0_rd_req = 1'b1; m0_rd_addr = 4'd2;
        m1_wr_req = 1'b1; m1_wr_addr = 4'd3; m1_wr_data = $urandom();
        #1;
        n_chk++;
        if ({m0_rd_gnt, m1_wr_gnt} !== 2'b11) begin
            n_err++;
            $display("FAIL conc_gnt: got %b expected 11", {m0_rd_gnt, m1_wr_gnt});
        end
        step_cycle();
        idle_inputs();
        #1;
        n_chk++;
        if ({rd_conflict_cnt, wr_conflict_cnt} !== '0) begin
            n_err++;
            $display("FAIL conc_cnt: got %0d/%0d expected 0/0", rd_conflict_cnt, wr_conflict_cnt);
        end
        step_cycle();
    endtask

    task automatic test_rr_fairness();
        apply_reset();
        m0_rd_req = 1'b1; m0_rd_addr = 4'd0;
        m1_rd_req = 1'b1; m1_rd_addr = 4'd1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_chk++;
            if ({m1_rd_gnt, m0_rd_gnt} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_err++;
                $display("FAIL fair_gnt[%0d]: got %b expected %b", i, {m1_rd_gnt, m0_rd_gnt},
                         (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            step_cycle();
        end
        idle_inputs();
        #1;
        n_chk++;
        if (rd_conflict_cnt !== 4'd6) begin
            n_err++;
            $display("FAIL fair_cnt: got %0d expected 6", rd_conflict_cnt);
        end
        step_cycle();
    endtask

    task automatic test_saturation();
        apply_reset();
        m0_rd_req = 1'b1; m1_rd_req = 1'b1;
        m0_wr_req = 1'b1; m1_wr_req = 1'b1;
        m1_wr_addr = 4'd9; m1_wr_data = 32'h5A5A;
        repeat (CNT_MAX + 5) step_cycle();
        idle_inputs();
        #1;
        n_chk++;
        if ({rd_conflict_cnt, wr_conflict_cnt} !== {4'd15, 4'd15}) begin
            n_err++;
            $display("FAIL sat_cnt: got %0d/%0d expected 15/15", rd_conflict_cnt, wr_conflict_cnt);
        end
        step_cycle();
    endtask

    task automatic test_mid_read_reset();
        apply_reset();
        m0_rd_req = 1'b1; m0_rd_addr = 4'd1;
        #1;
        n_chk++;
        if (m0_rd_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL mrr_gnt: got %b expected 1", m0_rd_gnt);
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if ({m1_rd_gnt, m0_rd_gnt} !== 2'b00) begin
            n_err++;
            $display("FAIL mrr_gnt_forced: got %b expected 00", {m1_rd_gnt, m0_rd_gnt});
        end
        m0_rd_req = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        if ({m1_rd_vld, m0_rd_vld} !== 2'b00) begin
            n_err++;
            $display("FAIL mrr_vld_drop: got %b expected 00", {m1_rd_vld, m0_rd_vld});
        end
        rst = 1'b1;
        model_reset();
        step_cycle();
        m0_rd_req = 1'b1; m0_rd_addr = 4'd2;
        step_cycle();
        m0_rd_req = 1'b0;
        #1;
        n_chk++;
        if (m0_rd_vld !== 1'b1) begin
            n_err++;
            $display("FAIL mrr_vld_set: got %b expected 1", m0_rd_vld);
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if (m0_rd_vld !== 1'b0) begin
            n_err++;
            $display("FAIL mrr_async_clear: got %b expected 0", m0_rd_vld);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        step_cycle();
    endtask

`ifdef MEM_ARB_RAW_FWD_EN
    task automatic test_raw_fwd();
        apply_reset();
        m0_wr_req = 1'b1; m0_wr_addr = 4'd5; m0_wr_data = 32'hDEAD;
        step_cycle();
        m0_wr_req = 1'b0;
        m0_rd_req = 1'b1; m0_rd_addr = 4'd5;
        m1_wr_req = 1'b1; m1_wr_addr = 4'd5; m1_wr_data = 32'h1234;
        step_cycle();
        idle_inputs();
        #1;
        n_chk++;
        if ({m0_rd_vld, m0_rd_data} !== {1'b1, 32'h1234}) begin
            n_err++;
            $display("FAIL raw_fwd: got vld=%b data=%h expected vld=1 data=1234", m0_rd_vld, m0_rd_data);
        end
        step_cycle();
    endtask
`endif

    // Requesters keep a request stable until granted, then draw a new one.
    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if (!m0_rd_req || rd_win == 0) begin
                m0_rd_req = ($urandom_range(2, 0) != 0);
                m0_rd_addr = AW'($urandom_range(7, 0));
            end
            if (!m1_rd_req || rd_win == 1) begin
                m1_rd_req = ($urandom_range(2, 0) != 0);
                m1_rd_addr = AW'($urandom_range(7, 0));
            end
            if (!m0_wr_req || wr_win == 0) begin
                m0_wr_req = ($urandom_range(2, 0) != 0);
                m0_wr_addr = AW'($urandom_range(7, 0));
                m0_wr_data = $urandom();
            end
            if (!m1_wr_req || wr_win == 1) begin
                m1_wr_req = ($urandom_range(2, 0) != 0);
                m1_wr_addr = AW'($urandom_range(7, 0));
                m1_wr_data = $urandom();
            end
            step_cycle();
        end
        idle_inputs();
        step_cycle();
        step_cycle();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) begin
            tb_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        test_reset();
        test_write_contention();
        test_read_routing();
        test_concurrent();
        test_rr_fairness();
        test_saturation();
        test_mid_read_reset();
`ifdef MEM_ARB_RAW_FWD_EN
        test_raw_fwd();
`endif
        test_random();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_1r1w_arbiter.md
Name: mem_1r1w_arbiter

Overview:
- Shares one mem_1r1w instance (one read port, one write port) between two requesters, m0 (core load/store) and m1 (loader/debug).
- Read and write channels are arbitrated independently, so one read and one write can issue in the same cycle.
- Read channel and write channel each use round-robin priority.
- Read responses are routed back to the owning requester one cycle after grant.
- Saturating contention counters are kept for performance debug.

Parameters:
- DATA_W, 32, data width; must match the mem_1r1w data width.
- ADDR_W, 4, address width; must match the mem_1r1w address width.
- CNT_W, 16, width of each contention counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- m0_rd_req, m1_rd_req  in  1  read request.
- m0_rd_addr, m1_rd_addr  in  ADDR_W  read address.
- m0_rd_gnt, m1_rd_gnt  out  1  read accepted this cycle.
- m0_rd_vld, m1_rd_vld  out  1  read data valid.
- m0_rd_data, m1_rd_data  out  DATA_W  read data.
- m0_wr_req, m1_wr_req  in  1  write request.
- m0_wr_addr, m1_wr_addr  in  ADDR_W  write address.
- m0_wr_data, m1_wr_data  in  DATA_W  write data.
- m0_wr_gnt, m1_wr_gnt  out  1  write accepted this cycle.
- mem_rd_addr0  out  ADDR_W  to mem_1r1w rd_addr0.
- mem_wr_addr0  out  ADDR_W  to mem_1r1w wr_addr0.
- mem_wr_din0  out  DATA_W  to mem_1r1w wr_din0.
- mem_we0  out  1  to mem_1r1w we0.
- mem_rd_dout0  in  DATA_W  from mem_1r1w rd_dout0; valid one cycle after the address is presented.
- rd_conflict_cnt  out  CNT_W  cycles in which both requesters asserted rd_req.
- wr_conflict_cnt  out  CNT_W  cycles in which both requesters asserted wr_req.

Behaviour:
- Reset: rst low clears all state immediately, with no clock edge needed.
  - Read and write priority pointers reset to prefer m0.
  - All rd_vld outputs go to 0; both counters go to 0.
  - While rst is low, all gnt outputs and mem_we0 are forced to 0.
- Grant logic is combinational from req and the pointer; there is no added latency.
  - A request is accepted in the cycle where req and gnt are both 1.
  - A requester holds req, addr and data stable until it sees gnt.
- Arbitration, per channel:
  - Only one requester asserts req: that requester is granted.
  - Both assert req: the requester the pointer prefers is granted.
  - On any grant, the pointer moves to prefer the other requester.
  - With no requests, the pointer holds its value.
- Write channel:
  - mem_we0 = m0_wr_gnt | m1_wr_gnt.
  - mem_wr_addr0 and mem_wr_din0 are muxed from the winner.
  - With no write grant, they drive m0's values, and mem_we0 is 0.
- Read channel:
  - mem_rd_addr0 is muxed from the winner, or m0_rd_addr when idle.
  - The arbiter registers the owner tag and a valid bit.
  - In the cycle after a grant, only the owner's rd_vld is 1.
  - Both rd_data outputs always carry mem_rd_dout0.
  - Back-to-back reads are supported: one per cycle, any owner sequence.
- Read and write from different requesters in the same cycle: both are granted.
- Same-address read and write in the same cycle: the result is mem_1r1w's read-during-write behaviour unless the forwarding feature below is compiled in.
- Counters:
  - Each increments on every cycle where both reqs on its channel are 1, with rst high.
  - Each saturates at 2^CNT_W-1.
- Reset during a read in flight: the pending rd_vld is dropped and never asserted.

Optional Feature:
- Macro: MEM_ARB_RAW_FWD_EN.
- Defined:
  - When a read grant and a write grant occur in the same cycle to equal addresses, the arbiter registers the write data and a forward flag.
  - In the next cycle, the owner's rd_data returns the forwarded data instead of mem_rd_dout0.
  - The forward flag clears on rst.
- Undefined: no forwarding registers; behaviour is as described above.

Decomposition:
- Shared package (mem_arb_pkg):
  - Requester ID encoding: M0=0, M1=1.
  - Counter saturation constant.
- Natural sub-module: rr_arb2, a 2-way round-robin arbiter with its pointer.
  - Inputs: clk, rst, req[1:0].
  - Output: gnt[1:0].
  - Instantiated twice, once for the read channel and once for the write channel.

Test Plan:
- Reset: hold rst=0 with all reqs at 1 → every gnt=0, mem_we0=0, rd_vld=0, both counters=0. Release rst → m0 is granted first.
- Write contention: m0 writes addr 0 / 31, m1 writes addr 1 / 0xA5 on the same cycle.
  - Cycle 1: m0_wr_gnt. Cycle 2: m1_wr_gnt.
  - mem_we0 is high in both cycles; wr_conflict_cnt=1.
- Read routing: mem pre-loaded with addr0=31, addr1=0xA5. m1 reads addr 1, then m0 reads addr 0 on the next cycle.
  - m1_rd_vld with 0xA5 one cycle after its grant.
  - Then m0_rd_vld with 31; the vld pulses never overlap.
- Concurrent read and write: m0 reads addr 2 while m1 writes addr 3 in the same cycle → both granted; no conflict count.
- Round-robin fairness: both rd_reqs held high for 6 cycles → grants alternate m0,m1,m0,m1,m0,m1; rd_conflict_cnt=6.
- Mid-read reset: rst pulsed low right after m0_rd_gnt → m0_rd_vld stays 0. With MEM_ARB_RAW_FWD_EN, same-cycle read and write to addr 5 with data 0x1234 returns 0x1234.
